// File: rtl/mem_arbiter.sv
// Two-port round-robin arbiter sharing a single-port synchronous memory.
// Each access runs IDLE -> ISSUE -> RESP; all outputs are registered.
module mem_arbiter #(
  parameter int DATA_WIDTH = 8,
  parameter int ADDR_BITS  = 5
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  req0,
  input  logic                  we0,
  input  logic [ADDR_BITS-1:0]  addr0,
  input  logic [DATA_WIDTH-1:0] wdata0,
  output logic                  ack0,
  output logic [DATA_WIDTH-1:0] rdata0,
  input  logic                  req1,
  input  logic                  we1,
  input  logic [ADDR_BITS-1:0]  addr1,
  input  logic [DATA_WIDTH-1:0] wdata1,
  output logic                  ack1,
  output logic [DATA_WIDTH-1:0] rdata1,
  output logic [ADDR_BITS-1:0]  mem_addr,
  output logic [DATA_WIDTH-1:0] mem_wdata,
  output logic                  mem_wen,
  input  logic [DATA_WIDTH-1:0] mem_rdata,
  output logic                  busy
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    RESP  = 2'd2
  } state_t;

  state_t                state_q, state_d;
  logic                  last_grant_q, last_grant_d;
  logic                  grant_q, grant_d;
  logic                  we_l_q, we_l_d;
  logic                  ack0_q, ack0_d;
  logic                  ack1_q, ack1_d;
  logic [DATA_WIDTH-1:0] rdata0_q, rdata0_d;
  logic [DATA_WIDTH-1:0] rdata1_q, rdata1_d;
  logic [ADDR_BITS-1:0]  mem_addr_q, mem_addr_d;
  logic [DATA_WIDTH-1:0] mem_wdata_q, mem_wdata_d;
  logic                  mem_wen_q, mem_wen_d;
  logic                  busy_q, busy_d;

  logic elig0, elig1, pick;

  always_comb begin
    // A port is masked during its own ack cycle so a held req is not re-granted early.
    elig0 = req0 && !ack0_q;
    elig1 = req1 && !ack1_q;
    pick  = (elig0 && elig1) ? !last_grant_q : elig1;

    state_d      = state_q;
    last_grant_d = last_grant_q;
    grant_d      = grant_q;
    we_l_d       = we_l_q;
    ack0_d       = 1'b0;
    ack1_d       = 1'b0;
    rdata0_d     = rdata0_q;
    rdata1_d     = rdata1_q;
    mem_addr_d   = mem_addr_q;
    mem_wdata_d  = mem_wdata_q;
    mem_wen_d    = mem_wen_q;
    busy_d       = busy_q;

    case (state_q)
      IDLE: begin
        if (elig0 || elig1) begin
          grant_d      = pick;
          last_grant_d = pick;
          we_l_d       = pick ? we1 : we0;
          mem_addr_d   = pick ? addr1 : addr0;
          mem_wdata_d  = pick ? wdata1 : wdata0;
          mem_wen_d    = pick ? we1 : we0;
          busy_d       = 1'b1;
          state_d      = ISSUE;
        end
      end
      ISSUE: begin
        mem_wen_d = 1'b0;
        state_d   = RESP;
      end
      RESP: begin
        if (!we_l_q) begin
          if (grant_q) rdata1_d = mem_rdata;
          else         rdata0_d = mem_rdata;
        end
        if (grant_q) ack1_d = 1'b1;
        else         ack0_d = 1'b1;
        busy_d  = 1'b0;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= IDLE;
      last_grant_q <= 1'b1;
      grant_q      <= 1'b0;
      we_l_q       <= 1'b0;
      ack0_q       <= 1'b0;
      ack1_q       <= 1'b0;
      rdata0_q     <= '0;
      rdata1_q     <= '0;
      mem_addr_q   <= '0;
      mem_wdata_q  <= '0;
      mem_wen_q    <= 1'b0;
      busy_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      last_grant_q <= last_grant_d;
      grant_q      <= grant_d;
      we_l_q       <= we_l_d;
      ack0_q       <= ack0_d;
      ack1_q       <= ack1_d;
      rdata0_q     <= rdata0_d;
      rdata1_q     <= rdata1_d;
      mem_addr_q   <= mem_addr_d;
      mem_wdata_q  <= mem_wdata_d;
      mem_wen_q    <= mem_wen_d;
      busy_q       <= busy_d;
    end
  end

  assign ack0      = ack0_q;
  assign ack1      = ack1_q;
  assign rdata0    = rdata0_q;
  assign rdata1    = rdata1_q;
  assign mem_addr  = mem_addr_q;
  assign mem_wdata = mem_wdata_q;
  assign mem_wen   = mem_wen_q;
  assign busy      = busy_q;

endmodule

// File: tb/tb_mem_arbiter.sv
// Bench for mem_arbiter: vector table plus arbitration/reset sequences, with an
// ack-driven scoreboard and a behavioural 32x8 memory attached to the memory pins.
module tb_mem_arbiter;
  localparam int DW = 8;
  localparam int AW = 5;

  logic          clk = 1'b0;
  logic          rst, load;
  logic          req0, we0, req1, we1;
  logic [AW-1:0] addr0, addr1;
  logic [DW-1:0] wdata0, wdata1;
  logic          ack0, ack1;
  logic [DW-1:0] rdata0, rdata1;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_wdata, mem_rdata;
  logic          mem_wen, busy;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  mem_arbiter #(.DATA_WIDTH(DW), .ADDR_BITS(AW)) dut (
    .clk(clk), .rst(rst),
    .req0(req0), .we0(we0), .addr0(addr0), .wdata0(wdata0), .ack0(ack0), .rdata0(rdata0),
    .req1(req1), .we1(we1), .addr1(addr1), .wdata1(wdata1), .ack1(ack1), .rdata1(rdata1),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_wen(mem_wen),
    .mem_rdata(mem_rdata), .busy(busy)
  );

  // Memory shares the arbiter's reset: writes sampled while rst is high are dropped.
  logic [DW-1:0] mem [32];
  always @(posedge clk) begin
    if (load) begin
      for (int i = 0; i < 32; i++) mem[i] <= 8'h80 + 8'(i);
    end else if (!rst && mem_wen) begin
      mem[mem_addr] <= mem_wdata;
    end
    mem_rdata <= mem_wen ? '0 : mem[mem_addr];
  end

  typedef struct {
    int         port;
    logic [7:0] rdata;
  } exp_t;
  exp_t sb[$];

  typedef struct {
    int         port;
    logic       we;
    logic [4:0] addr;
    logic [7:0] wdata;
    logic [7:0] exp_rd;
  } vec_t;
  vec_t tbl[8];

  logic [7:0] exp_mem [32];
  logic [7:0] exp_rd  [2];

  int         cyc = 0;
  int         ack_log[$];
  bit         busy_h[4096];
  bit         ack_h[4096];
  logic       prev_wen = 1'b0;
  int         wen_cnt = 0;
  logic [4:0] wen_addr;
  logic [7:0] wen_data;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Monitor: samples outputs on the falling edge and pops the scoreboard on every ack.
  initial begin
    forever begin
      @(negedge clk);
      cyc++;
      if (cyc < 4096) begin
        busy_h[cyc] = (busy === 1'b1);
        ack_h[cyc]  = (ack0 === 1'b1) || (ack1 === 1'b1);
      end
      if (mem_wen === 1'b1) begin
        chk("wen_single_cycle", 32'(prev_wen), 32'd0);
        wen_cnt++;
        wen_addr = mem_addr;
        wen_data = mem_wdata;
      end
      prev_wen = (mem_wen === 1'b1);
      if (ack0 === 1'b1 || ack1 === 1'b1) begin
        exp_t e;
        ack_log.push_back(cyc);
        chk("ack_onehot", 32'(ack0 & ack1), 32'd0);
        chk("busy_in_ack", 32'(busy), 32'd0);
        if (sb.size() == 0) begin
          chk("unexpected_ack", 32'd1, 32'd0);
        end else begin
          e = sb.pop_front();
          chk("ack_port", 32'(ack1), 32'(e.port));
          chk("ack_rdata", 32'(e.port != 0 ? rdata1 : rdata0), 32'(e.rdata));
        end
      end
    end
  end

  function automatic logic ack_of(input int p);
    return (p == 0) ? ack0 : ack1;
  endfunction

  task automatic drive(input int p, input logic r, input logic w, input logic [4:0] a,
                       input logic [7:0] d);
    if (p == 0) begin
      req0 = r; we0 = w; addr0 = a; wdata0 = d;
    end else begin
      req1 = r; we1 = w; addr1 = a; wdata1 = d;
    end
  endtask

  task automatic expect_txn(input int p, input logic w, input logic [4:0] a, input logic [7:0] d);
    if (w) exp_mem[a] = d;
    else   exp_rd[p] = exp_mem[a];
    sb.push_back('{p, exp_rd[p]});
  endtask

  // n back-to-back transactions on one port, req held through intermediate acks.
  task automatic port_seq(input int p, input int n, input logic w, input logic [4:0] a0,
                          input logic [7:0] d0, output int lat);
    int waitc;
    lat = -1;
    for (int k = 0; k < n; k++) begin
      drive(p, 1'b1, w, a0 + 5'(k), d0 + 8'(k));
      waitc = 0;
      do begin
        @(negedge clk);
        waitc++;
      end while (ack_of(p) !== 1'b1 && waitc < 20);
      #1;
      checks++;
      if (ack_of(p) !== 1'b1) begin
        errors++;
        $display("FAIL ack_timeout port%0d: got no ack, required ack within 20 cycles", p);
        drive(p, 1'b0, 1'b0, '0, '0);
        return;
      end
      if (k == 0) lat = waitc;
    end
    drive(p, 1'b0, 1'b0, '0, '0);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    exp_rd[0] = '0;
    exp_rd[1] = '0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got no finish, required finish before 200000");
    $fatal(1, "watchdog");
  end

  initial begin
    int lat, l0, l1, w0, first, last;

    tbl[0] = '{0, 1'b1, 5'd5,  8'hA5, 8'h00};
    tbl[1] = '{1, 1'b0, 5'd5,  8'h00, 8'hA5};
    tbl[2] = '{0, 1'b0, 5'd9,  8'h00, 8'h89};
    tbl[3] = '{1, 1'b1, 5'd31, 8'h3C, 8'hA5};
    tbl[4] = '{0, 1'b0, 5'd31, 8'h00, 8'h3C};
    tbl[5] = '{1, 1'b0, 5'd0,  8'h00, 8'h80};
    tbl[6] = '{0, 1'b1, 5'd0,  8'hFF, 8'h3C};
    tbl[7] = '{1, 1'b0, 5'd0,  8'h00, 8'hFF};
    for (int i = 0; i < 32; i++) exp_mem[i] = 8'h80 + 8'(i);

    drive(0, 1'b0, 1'b0, '0, '0);
    drive(1, 1'b0, 1'b0, '0, '0);
    load = 1'b1;
    rst  = 1'b1;
    repeat (3) @(negedge clk);
    load = 1'b0;
    rst  = 1'b0;
    exp_rd[0] = '0;
    exp_rd[1] = '0;

    // Reset state
    chk("rst_ack0", 32'(ack0), 32'd0);
    chk("rst_ack1", 32'(ack1), 32'd0);
    chk("rst_rdata0", 32'(rdata0), 32'd0);
    chk("rst_rdata1", 32'(rdata1), 32'd0);
    chk("rst_mem_addr", 32'(mem_addr), 32'd0);
    chk("rst_mem_wdata", 32'(mem_wdata), 32'd0);
    chk("rst_mem_wen", 32'(mem_wen), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);

    // Single transactions from the vector table
    foreach (tbl[i]) begin
      sb.push_back('{tbl[i].port, tbl[i].exp_rd});
      if (tbl[i].we) exp_mem[tbl[i].addr] = tbl[i].wdata;
      else           exp_rd[tbl[i].port] = exp_mem[tbl[i].addr];
      w0 = wen_cnt;
      port_seq(tbl[i].port, 1, tbl[i].we, tbl[i].addr, tbl[i].wdata, lat);
      chk("latency", 32'(lat), 32'd3);
      chk("wen_pulses", 32'(wen_cnt - w0), 32'(tbl[i].we));
      if (tbl[i].we) begin
        chk("wen_addr", 32'(wen_addr), 32'(tbl[i].addr));
        chk("wen_data", 32'(wen_data), 32'(tbl[i].wdata));
      end
      @(negedge clk);
    end

    // Simultaneous requests after reset: port 0 wins the first tie
    do_reset();
    expect_txn(0, 1'b1, 5'd1, 8'h11);
    expect_txn(1, 1'b1, 5'd2, 8'h22);
    w0 = wen_cnt;
    fork
      port_seq(0, 1, 1'b1, 5'd1, 8'h11, l0);
      port_seq(1, 1, 1'b1, 5'd2, 8'h22, l1);
    join
    @(negedge clk);
    #1;
    chk("tie_wen_pulses", 32'(wen_cnt - w0), 32'd2);
    expect_txn(0, 1'b0, 5'd1, 8'h00);
    port_seq(0, 1, 1'b0, 5'd1, 8'h00, lat);
    @(negedge clk);
    expect_txn(1, 1'b0, 5'd2, 8'h00);
    port_seq(1, 1, 1'b0, 5'd2, 8'h00, lat);
    @(negedge clk);

    // Continuous requests from both ports: 0,1,0,1 with busy low only in ack cycles
    do_reset();
    ack_log.delete();
    expect_txn(0, 1'b1, 5'd10, 8'h40);
    expect_txn(1, 1'b0, 5'd10, 8'h00);
    expect_txn(0, 1'b1, 5'd11, 8'h41);
    expect_txn(1, 1'b0, 5'd11, 8'h00);
    fork
      port_seq(0, 2, 1'b1, 5'd10, 8'h40, l0);
      port_seq(1, 2, 1'b0, 5'd10, 8'h00, l1);
    join
    @(negedge clk);
    #1;
    chk("rr_ack_count", 32'(ack_log.size()), 32'd4);
    if (ack_log.size() >= 2) begin
      first = ack_log[0];
      last  = ack_log[ack_log.size() - 1];
      for (int c = first; c <= last && c < 4096; c++)
        chk("rr_busy_low_iff_ack", 32'(busy_h[c]), 32'(!ack_h[c]));
    end

    // Port 0 re-requests through its ack with port 1 idle
    ack_log.delete();
    expect_txn(0, 1'b0, 5'd1, 8'h00);
    expect_txn(0, 1'b0, 5'd2, 8'h00);
    port_seq(0, 2, 1'b0, 5'd1, 8'h00, lat);
    @(negedge clk);
    #1;
    if (ack_log.size() == 2) chk("rereq_ack_gap", 32'(ack_log[1] - ack_log[0]), 32'd4);
    else                     chk("rereq_ack_count", 32'(ack_log.size()), 32'd2);

    // Reset during ISSUE of a port 1 write
    do_reset();
    drive(1, 1'b1, 1'b1, 5'd7, 8'h77);
    @(negedge clk);
    chk("abort_busy_issue", 32'(busy), 32'd1);
    chk("abort_wen_issue", 32'(mem_wen), 32'd1);
    chk("abort_addr_issue", 32'(mem_addr), 32'd7);
    rst = 1'b1;
    @(negedge clk);
    chk("abort_ack0", 32'(ack0), 32'd0);
    chk("abort_ack1", 32'(ack1), 32'd0);
    chk("abort_rdata0", 32'(rdata0), 32'd0);
    chk("abort_rdata1", 32'(rdata1), 32'd0);
    chk("abort_mem_addr", 32'(mem_addr), 32'd0);
    chk("abort_mem_wdata", 32'(mem_wdata), 32'd0);
    chk("abort_mem_wen", 32'(mem_wen), 32'd0);
    chk("abort_busy", 32'(busy), 32'd0);
    rst = 1'b0;
    drive(1, 1'b0, 1'b0, '0, '0);
    exp_rd[0] = '0;
    exp_rd[1] = '0;
    repeat (3) @(negedge clk);
    #1;
    chk("abort_no_late_ack", 32'(sb.size()), 32'd0);
    expect_txn(0, 1'b0, 5'd7, 8'h00);
    port_seq(0, 1, 1'b0, 5'd7, 8'h00, lat);
    repeat (2) @(negedge clk);
    #1;
    chk("scoreboard_drained", 32'(sb.size()), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
